// File: rtl/riscv_pkg.sv
// Shared types and defaults for the data-memory arbiter.
package riscv_pkg;

    localparam int unsigned DMEM_DEPTH = 1024;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } dmem_state_e;

    typedef logic req_id_t;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin grant: pointer picks the winner only when both requesters are valid.
module rr_arbiter2
    import riscv_pkg::*;
(
    input  logic [1:0] valid_i,
    input  req_id_t    ptr_i,
    output logic [1:0] gnt_o
);

    always_comb begin
        gnt_o    = 2'b00;
        gnt_o[0] = valid_i[0] & (~valid_i[1] | ~ptr_i);
        gnt_o[1] = valid_i[1] & (~valid_i[0] | ptr_i);
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Arbitrates a core LSU and a debug/DMA port onto one single-port data memory.
// Each accepted request takes IDLE -> ACCESS -> RESP, one request per three cycles.
module dmem_arbiter
    import riscv_pkg::*;
#(
    parameter int unsigned  DEPTH = DMEM_DEPTH,
    localparam int unsigned AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic [1:0]    req_valid,
    output logic [1:0]    req_ready,
    input  logic [1:0]    req_we,
    input  logic [63:0]   req_addr,
    input  logic [63:0]   req_wdata,
    output logic [1:0]    rsp_valid,
    output logic [63:0]   rsp_rdata,
    output logic [1:0]    rsp_err,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [31:0]   mem_wdata,
    input  logic [31:0]   mem_rdata
);

    dmem_state_e      state_q, state_d;
    req_id_t          ptr_q, ptr_d;
    req_id_t          id_q, id_d;
    logic             we_q, we_d;
    logic             err_q, err_d;
    logic [AW-1:0]    addr_q, addr_d;
    logic [31:0]      wdata_q, wdata_d;
    logic [1:0]       rsp_valid_q, rsp_valid_d;
    logic [1:0]       rsp_err_q, rsp_err_d;
    logic [1:0][31:0] rdata_q, rdata_d;

    logic [1:0]  gnt;
    req_id_t     win;
    logic [31:0] sel_addr;
    logic [31:0] sel_wdata;
    logic        sel_we;
    logic        sel_legal;
    logic        hs;

    rr_arbiter2 u_rr (
        .valid_i (req_valid),
        .ptr_i   (ptr_q),
        .gnt_o   (gnt)
    );

    always_comb begin
        win       = gnt[1];
        sel_addr  = win ? req_addr[63:32]  : req_addr[31:0];
        sel_wdata = win ? req_wdata[63:32] : req_wdata[31:0];
        sel_we    = win ? req_we[1]        : req_we[0];
        // Word aligned and inside the DEPTH-word window.
        sel_legal = (sel_addr[1:0] == 2'b00) && ((sel_addr >> (AW + 2)) == 32'd0);
        // Ready is also held low while reset is asserted.
        req_ready = (state_q == IDLE && resetn) ? gnt : 2'b00;
        hs        = |(req_valid & req_ready);
    end

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        id_d        = id_q;
        we_d        = we_q;
        err_d       = err_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        rdata_d     = rdata_q;
        rsp_valid_d = 2'b00;
        rsp_err_d   = 2'b00;
        unique case (state_q)
            IDLE: begin
                if (hs) begin
                    id_d    = win;
                    we_d    = sel_we;
                    err_d   = ~sel_legal;
                    addr_d  = sel_addr[AW+1:2];
                    wdata_d = sel_wdata;
                    ptr_d   = ~win;
                    state_d = ACCESS;
                end
            end
            ACCESS: begin
                rsp_valid_d[id_q] = 1'b1;
                rsp_err_d[id_q]   = err_q;
                rdata_d[id_q]     = (!we_q && !err_q) ? mem_rdata : 32'd0;
                state_d           = RESP;
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= IDLE;
            ptr_q       <= 1'b0;
            id_q        <= 1'b0;
            we_q        <= 1'b0;
            err_q       <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= 32'd0;
            rsp_valid_q <= 2'b00;
            rsp_err_q   <= 2'b00;
            rdata_q     <= '0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            id_q        <= id_d;
            we_q        <= we_d;
            err_q       <= err_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            rdata_q     <= rdata_d;
        end
    end

    // Write strobe derives from state so reset kills it without waiting for an edge.
    assign mem_we    = (state_q == ACCESS) && we_q && !err_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_err   = rsp_err_q;
    assign rsp_rdata = {rdata_q[1], rdata_q[0]};

endmodule
